// File: rtl/wb_retire_queue.sv
// In-order write-back retire queue between MEM and the register-file write port.
// Retires at most one instruction per cycle, forwards pending results youngest-first and reports each retire on the debug outputs.
module wb_retire_queue #(
    parameter int PC_W   = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int BUS_W  = PC_W + 1 + ADDR_W + DATA_W
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ms_to_ws_valid,
    input  logic [BUS_W-1:0]             ms_ws_bus,
    output logic                         ws_allow_in,
    output logic [ADDR_W+DATA_W:0]       ws_rf_bus,
    input  logic                         rf_ready,
    input  logic [ADDR_W-1:0]            fwd_raddr1,
    input  logic [ADDR_W-1:0]            fwd_raddr2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   ws_count,
    output logic [PC_W-1:0]              debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [ADDR_W-1:0]            debug_wb_rf_wnum,
    output logic [DATA_W-1:0]            debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic              we_q   [DEPTH];
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] res_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PC_W-1:0]   in_pc;
    logic              in_we;
    logic [ADDR_W-1:0] in_dest;
    logic [DATA_W-1:0] in_res;

    assign in_pc   = ms_ws_bus[BUS_W-1 -: PC_W];
    assign in_we   = ms_ws_bus[ADDR_W+DATA_W];
    assign in_dest = ms_ws_bus[DATA_W +: ADDR_W];
    assign in_res  = ms_ws_bus[DATA_W-1:0];

    logic head_valid, head_we, push, retire;

    assign head_valid  = (count_q != '0);
    assign head_we     = we_q[head_q];
    // Full refuses a push even when the head retires in the same cycle,
    // which keeps rf_ready off the ws_allow_in path.
    assign ws_allow_in = (count_q != CNT_W'(DEPTH));
    assign push        = ms_to_ws_valid & ws_allow_in;
    assign retire      = head_valid & (~head_we | rf_ready);
    assign ws_count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push)   tail_d = tail_q + 1'b1;
        if (retire) head_d = head_q + 1'b1;
        case ({push, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]   <= in_pc;
            we_q[tail_q]   <= in_we;
            dest_q[tail_q] <= in_dest;
            res_q[tail_q]  <= in_res;
        end
    end

    logic rf_we;
    assign rf_we     = head_valid & head_we;
    assign ws_rf_bus = rf_we ? {1'b1, dest_q[head_q], res_q[head_q]} : '0;

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_we    = 4'h0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (retire) begin
            debug_wb_pc = pc_q[head_q];
            if (head_we) begin
                debug_wb_rf_we    = 4'hF;
                debug_wb_rf_wnum  = dest_q[head_q];
                debug_wb_rf_wdata = res_q[head_q];
            end
        end
    end

    // Entries are viewed by age (0 = head); larger age is younger.
    logic [DEPTH-1:0]  match1_age;
    logic [DEPTH-1:0]  match2_age;
    logic [DATA_W-1:0] data_age [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PTR_W-1:0] slot;
        logic             live;
        assign slot = head_q + PTR_W'(gi);
        assign live = (CNT_W'(gi) < count_q) & we_q[slot];
        assign match1_age[gi] = live & (dest_q[slot] == fwd_raddr1) & (fwd_raddr1 != '0);
        assign match2_age[gi] = live & (dest_q[slot] == fwd_raddr2) & (fwd_raddr2 != '0);
        assign data_age[gi]   = res_q[slot];
    end

    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match1_age[i]) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_age[i];
            end
            if (match2_age[i]) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_age[i];
            end
        end
    end

endmodule
